thor2023_wb_sram_responder: RTL and testbench



---
 rtl/thor2023_wb_sram_responder_pkg.sv | 40 ++++
 rtl/thor2023_sram_1rw128.sv | 37 +++
 rtl/thor2023_wb_sram_responder.sv | 184 ++++++++++++++++++
 tb/tb_thor2023_wb_sram_responder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/thor2023_wb_sram_responder_pkg.sv
// Shared Wishbone 128-bit command/response types and cycle-type constants
// used by the scratchpad SRAM responder.
package thor2023_wb_sram_responder_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef logic [7:0] wb_tranid_t;

    typedef struct packed {
        logic         cyc;
        logic         stb;
        logic         we;
        logic [15:0]  sel;
        logic [31:0]  adr;
        logic [127:0] data1;
        logic [2:0]   cti;
        logic [1:0]   bte;
        logic [5:0]   blen;
        wb_tranid_t   tid;
        logic         csr;
    } wb_cmd_request128_t;

    typedef struct packed {
        logic         ack;
        logic         next;
        logic         rty;
        logic         err;
        wb_tranid_t   tid;
        logic [31:0]  adr;
        logic [127:0] dat;
    } wb_cmd_response128_t;

    function automatic logic is_incr(input logic [2:0] cti);
        return cti == CTI_INCR;
    endfunction

endpackage

// File: rtl/thor2023_sram_1rw128.sv
// Single-port 2^DEPTH_LOG2 x 128 SRAM with per-byte write enables.
// Read data is registered, then delayed by LATENCY-1 extra stages that advance every cycle.
module thor2023_sram_1rw128 #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 1
) (
    input  logic                  clk_i,
    input  logic [15:0]           we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [127:0]          wdata,
    output logic [127:0]          rdata
);

    logic [127:0] mem [2**DEPTH_LOG2];
    logic [127:0] rd_q;

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 16; i++) begin
            if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
        rd_q <= mem[addr];
    end

    generate
        if (LATENCY > 1) begin : g_pipe
            logic [127:0] stage [LATENCY-1];
            always_ff @(posedge clk_i) begin
                stage[0] <= rd_q;
                for (int i = 1; i < LATENCY - 1; i++) stage[i] <= stage[i-1];
            end
            assign rdata = stage[LATENCY-2];
        end else begin : g_nopipe
            assign rdata = rd_q;
        end
    endgenerate

endmodule

// File: rtl/thor2023_wb_sram_responder.sv
// Wishbone 128-bit responder on a byte-writable scratchpad SRAM with one LR/SC reservation.
// Write/error respond one cycle after accept, reads after RD_LATENCY; one request at a time, master holds stb until served.
module thor2023_wb_sram_responder
    import thor2023_wb_sram_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADR   = 32'hFFFC0000,
    parameter int          DEPTH_LOG2 = 10,
    parameter int          RD_LATENCY = 1,
    parameter int          MAX_BLEN   = 15
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  wb_cmd_request128_t  wbs_req,
    output wb_cmd_response128_t wbs_resp
);

    localparam int LW = DEPTH_LOG2;

    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_BEAT, WR_ACK, ERR, REL} state_t;

    state_t state, state_nxt;

    logic          hit;
    logic [LW-1:0] req_line;
    logic [LW:0]   end_line;
    logic          req_err;

    wb_tranid_t    tid_q;
    logic [31:0]   adr_q;
    logic          burst_q;
    logic [5:0]    blen_q;
    logic          csr_q;
    logic [15:0]   sel_q;
    logic [127:0]  wdat_q;
    logic [LW-1:0] line_q;
    logic [LW-1:0] rd_ptr;
    logic [5:0]    beat_cnt;
    logic [1:0]    wait_cnt;
    logic          resv_valid;
    logic [LW-1:0] resv_line;

    logic          last_beat;
    logic          sc_ok;
    logic [LW-1:0] beat_line;
    logic [LW-1:0] ram_addr;
    logic [15:0]   ram_we;
    logic [127:0]  ram_rdata;

    assign hit      = wbs_req.cyc & wbs_req.stb &
                      (wbs_req.adr[31:LW+4] == BASE_ADR[31:LW+4]);
    assign req_line = wbs_req.adr[LW+3:4];
    assign end_line = {1'b0, req_line} + (LW+1)'(wbs_req.blen);

    // A reserve/conditional access only makes sense for a single line.
    assign req_err  = (is_incr(wbs_req.cti) &
                       (wbs_req.we | (wbs_req.bte != BTE_LINEAR) | wbs_req.csr)) |
                      (wbs_req.blen > 6'(MAX_BLEN)) |
                      (end_line > (LW+1)'(2**LW - 1));

    assign last_beat = !burst_q || (beat_cnt == blen_q);
    assign sc_ok     = resv_valid && (resv_line == line_q);
    assign beat_line = line_q + LW'(beat_cnt);

    // The read pointer runs ahead of the beat counter by the RAM read latency.
    always_comb begin
        ram_addr = rd_ptr;
        if (state == IDLE)        ram_addr = req_line;
        else if (state == WR_ACK) ram_addr = line_q;
    end

    assign ram_we = (state == WR_ACK && (!csr_q || sc_ok)) ? sel_q : 16'h0000;

    thor2023_sram_1rw128 #(
        .DEPTH_LOG2 (LW),
        .LATENCY    (RD_LATENCY)
    ) u_ram (
        .clk_i (clk_i),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdat_q),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (hit) begin
                    if (req_err)              state_nxt = ERR;
                    else if (wbs_req.we)      state_nxt = WR_ACK;
                    else if (RD_LATENCY == 1) state_nxt = RD_BEAT;
                    else                      state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: if (wait_cnt == 2'(RD_LATENCY - 2)) state_nxt = RD_BEAT;
            RD_BEAT: if (last_beat) state_nxt = REL;
            WR_ACK:  state_nxt = REL;
            ERR:     state_nxt = REL;
            REL:     if (!wbs_req.stb) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wbs_resp = '0;
        unique case (state)
            RD_BEAT: begin
                wbs_resp.ack  = 1'b1;
                wbs_resp.next = !last_beat;
                wbs_resp.tid  = tid_q;
                wbs_resp.adr  = {{(28-LW){1'b0}}, beat_line, 4'b0000};
                wbs_resp.dat  = ram_rdata;
            end
            WR_ACK: begin
                wbs_resp.ack  = 1'b1;
                wbs_resp.tid  = tid_q;
                wbs_resp.adr  = adr_q;
                wbs_resp.dat  = {127'd0, csr_q & sc_ok};
            end
            ERR: begin
                wbs_resp.err  = 1'b1;
                wbs_resp.tid  = tid_q;
                wbs_resp.adr  = adr_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tid_q      <= '0;
            adr_q      <= '0;
            burst_q    <= 1'b0;
            blen_q     <= '0;
            csr_q      <= 1'b0;
            sel_q      <= '0;
            wdat_q     <= '0;
            line_q     <= '0;
            rd_ptr     <= '0;
            beat_cnt   <= '0;
            wait_cnt   <= '0;
            resv_valid <= 1'b0;
            resv_line  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (hit) begin
                        tid_q    <= wbs_req.tid;
                        adr_q    <= wbs_req.adr;
                        burst_q  <= is_incr(wbs_req.cti);
                        blen_q   <= wbs_req.blen;
                        csr_q    <= wbs_req.csr;
                        sel_q    <= wbs_req.sel;
                        wdat_q   <= wbs_req.data1;
                        line_q   <= req_line;
                        rd_ptr   <= req_line + LW'(1);
                        beat_cnt <= '0;
                        wait_cnt <= '0;
                    end
                end
                RD_WAIT: begin
                    wait_cnt <= wait_cnt + 2'd1;
                    rd_ptr   <= rd_ptr + LW'(1);
                end
                RD_BEAT: begin
                    rd_ptr   <= rd_ptr + LW'(1);
                    beat_cnt <= beat_cnt + 6'd1;
                    if (last_beat && csr_q) begin
                        resv_valid <= 1'b1;
                        resv_line  <= line_q;
                    end
                end
                WR_ACK: if (csr_q || sc_ok) resv_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_thor2023_wb_sram_responder.sv
// Bench for the Wishbone SRAM responder: directed cases plus randomized traffic
// compared against a line-level memory/reservation model.
module tb_thor2023_wb_sram_responder;
    import thor2023_wb_sram_responder_pkg::*;

    localparam int          RDL  = 1;
    localparam logic [31:0] BASE = 32'hFFFC0000;

    logic                clk_i = 1'b0;
    logic                rst_i = 1'b1;
    wb_cmd_request128_t  wbs_req;
    wb_cmd_response128_t wbs_resp;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    thor2023_wb_sram_responder #(
        .BASE_ADR   (BASE),
        .DEPTH_LOG2 (10),
        .RD_LATENCY (RDL),
        .MAX_BLEN   (15)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .wbs_req  (wbs_req),
        .wbs_resp (wbs_resp)
    );

    typedef struct {
        logic         ack;
        logic         next;
        logic         err;
        logic [7:0]   tid;
        bit           chk_adr;
        logic [31:0]  adr;
        bit           chk_dat;
        logic [127:0] dat;
    } exp_t;

    exp_t         exp_q[$];
    logic [127:0] mdl_mem [1024];
    bit           mdl_rv = 1'b0;
    int           mdl_rl = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    function automatic wb_cmd_request128_t mk(input logic we, input logic [15:0] sel,
            input logic [31:0] adr, input logic [127:0] data, input logic [2:0] cti,
            input logic [1:0] bte, input logic [5:0] blen, input logic [7:0] tid, input logic csr);
        wb_cmd_request128_t r;
        r = '0;
        r.cyc = 1'b1; r.stb = 1'b1; r.we = we; r.sel = sel; r.adr = adr; r.data1 = data;
        r.cti = cti; r.bte = bte; r.blen = blen; r.tid = tid; r.csr = csr;
        return r;
    endfunction

    // Expected responses for one request; n = response count, lat = negedges from drive to first response.
    task automatic model_txn(input wb_cmd_request128_t r, output int n, output int lat);
        int   idx, nb;
        bit   burst, bad, ok, match;
        exp_t e;
        n = 0; lat = 0;
        if (r.adr[31:14] != BASE[31:14]) return;
        idx   = int'(r.adr[13:4]);
        burst = (r.cti == CTI_INCR);
        bad   = (burst && (r.we || r.bte != BTE_LINEAR || r.csr)) ||
                (r.blen > 6'd15) || (idx + int'(r.blen) > 1023);
        e = '{ack: 1'b0, next: 1'b0, err: 1'b0, tid: r.tid, chk_adr: 1'b0, adr: '0, chk_dat: 1'b0, dat: '0};
        if (bad) begin
            e.err = 1'b1;
            exp_q.push_back(e);
            n = 1; lat = 2;
        end else if (r.we) begin
            match = mdl_rv && (mdl_rl == idx);
            ok    = !r.csr || match;
            if (ok)
                for (int b = 0; b < 16; b++)
                    if (r.sel[b]) mdl_mem[idx][8*b +: 8] = r.data1[8*b +: 8];
            if (r.csr || match) mdl_rv = 1'b0;
            e.ack = 1'b1; e.chk_dat = 1'b1; e.dat = {127'd0, r.csr & ok};
            exp_q.push_back(e);
            n = 1; lat = 2;
        end else begin
            nb = burst ? int'(r.blen) + 1 : 1;
            for (int k = 0; k < nb; k++) begin
                e.ack = 1'b1; e.next = (k < nb - 1);
                e.chk_adr = 1'b1; e.adr = 32'((idx + k) * 16);
                e.chk_dat = 1'b1; e.dat = mdl_mem[idx + k];
                exp_q.push_back(e);
            end
            if (r.csr) begin mdl_rv = 1'b1; mdl_rl = idx; end
            n = nb; lat = 1 + RDL;
        end
    endtask

    task automatic txn(input wb_cmd_request128_t r, output wb_cmd_response128_t first, output int nresp);
        int exp_n, exp_lat, lat;
        model_txn(r, exp_n, exp_lat);
        @(posedge clk_i); #1;
        wbs_req = r;
        nresp = 0; lat = -1; first = '0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk_i);
            if (wbs_resp.ack || wbs_resp.err) begin
                if (nresp == 0) begin lat = c; first = wbs_resp; end
                nresp++;
            end else if (nresp > 0) break;
        end
        chk("response count", 128'(nresp), 128'(exp_n));
        if (exp_n > 0) chk("first response latency", 128'(lat), 128'(exp_lat));
        exp_q.delete();
        @(posedge clk_i); #1;
        wbs_req = '0;
    endtask

    always @(negedge clk_i) begin
        exp_t e;
        if (!rst_i) begin
            chk("rty idle", 128'(wbs_resp.rty), 128'(0));
            if (wbs_resp.ack || wbs_resp.err || wbs_resp.next) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected response", 128'(wbs_resp.ack | wbs_resp.err), 128'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("ack", 128'(wbs_resp.ack), 128'(e.ack));
                    chk("next", 128'(wbs_resp.next), 128'(e.next));
                    chk("err", 128'(wbs_resp.err), 128'(e.err));
                    chk("tid", 128'(wbs_resp.tid), 128'(e.tid));
                    if (e.chk_adr) chk("beat adr", 128'(wbs_resp.adr), 128'(e.adr));
                    if (e.chk_dat) chk("dat", wbs_resp.dat, e.dat);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        wb_cmd_response128_t f;
        wb_cmd_request128_t  r;
        int n, lat, cnt, line, sel_r;
        logic [31:0] adr;
        logic [127:0] d;
        logic [2:0] cti;
        logic we;

        wbs_req = '0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset ack", 128'(wbs_resp.ack), 128'(0));
        chk("reset next", 128'(wbs_resp.next), 128'(0));
        chk("reset err", 128'(wbs_resp.err), 128'(0));
        chk("reset tid", 128'(wbs_resp.tid), 128'(0));
        chk("reset adr", 128'(wbs_resp.adr), 128'(0));
        chk("reset dat", wbs_resp.dat, 128'(0));
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        for (int i = 0; i < 48; i++) begin
            line = (i < 32) ? i : 1008 + (i - 32);
            d = {$urandom, $urandom, $urandom, $urandom};
            txn(mk(1, 16'hFFFF, BASE | 32'(line * 16), d, CTI_CLASSIC, BTE_LINEAR, 0, 8'(i), 0), f, n);
        end

        // Full write then read back.
        txn(mk(1, 16'hFFFF, 32'hFFFC0010, 128'h00112233_44556677_8899AABB_CCDDEEFF,
               CTI_CLASSIC, BTE_LINEAR, 0, 8'd5, 0), f, n);
        chk("t1 write tid", 128'(f.tid), 128'(5));
        txn(mk(0, 16'h0000, 32'hFFFC0010, '0, CTI_CLASSIC, BTE_LINEAR, 0, 8'd9, 0), f, n);
        chk("t1 read data", f.dat, 128'h00112233_44556677_8899AABB_CCDDEEFF);
        chk("t1 read tid", 128'(f.tid), 128'(9));

        // Single byte lane.
        txn(mk(1, 16'h0001, 32'hFFFC0010, 128'h5555_5555_5555_5555_5555_5555_5555_55AA,
               CTI_CLASSIC, BTE_LINEAR, 0, 8'd6, 0), f, n);
        txn(mk(0, 16'h0000, 32'hFFFC001C, '0, CTI_EOB, BTE_LINEAR, 0, 8'd7, 0), f, n);
        chk("t2 byte lane data", f.dat, 128'h00112233_44556677_8899AABB_CCDDEEAA);

        // Linear burst.
        for (int i = 0; i < 4; i++)
            txn(mk(1, 16'hFFFF, BASE | 32'(i * 16), 128'(16 + i), CTI_CLASSIC, BTE_LINEAR, 0, 8'(i), 0), f, n);
        txn(mk(0, 16'h0000, BASE, '0, CTI_INCR, BTE_LINEAR, 3, 8'h33, 0), f, n);
        chk("t3 beat count", 128'(n), 128'(4));
        chk("t3 first beat", f.dat, 128'h10);
        chk("t3 first next", 128'(f.next), 128'(1));

        // Load-reserve / store-conditional.
        txn(mk(0, 16'h0000, 32'hFFFC0080, '0, CTI_CLASSIC, BTE_LINEAR, 0, 8'h40, 1), f, n);
        txn(mk(1, 16'hFFFF, 32'hFFFC0080, 128'hD4, CTI_CLASSIC, BTE_LINEAR, 0, 8'h41, 1), f, n);
        chk("t4 sc success", f.dat, 128'd1);
        txn(mk(0, 16'h0000, 32'hFFFC0080, '0, CTI_CLASSIC, BTE_LINEAR, 0, 8'h42, 0), f, n);
        chk("t4 sc wrote", f.dat, 128'hD4);
        txn(mk(1, 16'hFFFF, 32'hFFFC0080, 128'hD5, CTI_CLASSIC, BTE_LINEAR, 0, 8'h43, 1), f, n);
        chk("t4 repeat sc fails", f.dat, 128'd0);
        txn(mk(0, 16'h0000, 32'hFFFC0080, '0, CTI_CLASSIC, BTE_LINEAR, 0, 8'h44, 0), f, n);
        chk("t4 failed sc no write", f.dat, 128'hD4);
        txn(mk(0, 16'h0000, 32'hFFFC0080, '0, CTI_CLASSIC, BTE_LINEAR, 0, 8'h45, 1), f, n);
        txn(mk(1, 16'hFFFF, 32'hFFFC0080, 128'hD6, CTI_CLASSIC, BTE_LINEAR, 0, 8'h46, 0), f, n);
        txn(mk(1, 16'hFFFF, 32'hFFFC0080, 128'hD7, CTI_CLASSIC, BTE_LINEAR, 0, 8'h47, 1), f, n);
        chk("t4 sc after plain write", f.dat, 128'd0);
        txn(mk(0, 16'h0000, 32'hFFFC0080, '0, CTI_CLASSIC, BTE_LINEAR, 0, 8'h48, 0), f, n);
        chk("t4 line after sc fail", f.dat, 128'hD6);

        // Error cases.
        txn(mk(0, 16'h0000, 32'hFFFC3FF0, '0, CTI_INCR, BTE_LINEAR, 2, 8'h50, 0), f, n);
        chk("t5 burst off end err", 128'(f.err), 128'(1));
        txn(mk(0, 16'h0000, BASE, '0, CTI_INCR, 2'b01, 0, 8'h51, 0), f, n);
        chk("t5 wrap bte err", 128'(f.err), 128'(1));
        txn(mk(0, 16'h0000, BASE, '0, CTI_INCR, BTE_LINEAR, 16, 8'h52, 0), f, n);
        chk("t5 blen too large err", 128'(f.err), 128'(1));
        txn(mk(1, 16'hFFFF, BASE, 128'hBAD, CTI_INCR, BTE_LINEAR, 1, 8'h53, 0), f, n);
        chk("t5 burst write err", 128'(f.err), 128'(1));
        chk("t5 burst write tid", 128'(f.tid), 128'(8'h53));
        txn(mk(0, 16'h0000, BASE, '0, CTI_CLASSIC, BTE_LINEAR, 0, 8'h54, 0), f, n);
        chk("t5 line 0 unchanged", f.dat, 128'h10);
        txn(mk(0, 16'h0000, 32'hFFFC3FF0, '0, CTI_CLASSIC, BTE_LINEAR, 0, 8'h55, 0), f, n);

        // Reset in the middle of a burst.
        r = mk(0, 16'h0000, BASE, '0, CTI_INCR, BTE_LINEAR, 7, 8'h66, 0);
        model_txn(r, n, lat);
        @(posedge clk_i); #1;
        wbs_req = r;
        cnt = 0;
        for (int c = 0; c < 20 && cnt < 2; c++) begin
            @(negedge clk_i);
            if (wbs_resp.ack) cnt++;
        end
        chk("t6 beats before reset", 128'(cnt), 128'(2));
        @(posedge clk_i); #2;
        chk("t6 beat2 ack", 128'(wbs_resp.ack), 128'(1));
        chk("t6 beat2 data", wbs_resp.dat, 128'h12);
        rst_i = 1'b1;
        exp_q.delete();
        mdl_rv = 1'b0;
        #1;
        chk("t6 ack drops", 128'(wbs_resp.ack), 128'(0));
        chk("t6 next drops", 128'(wbs_resp.next), 128'(0));
        chk("t6 err drops", 128'(wbs_resp.err), 128'(0));
        wbs_req = '0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        txn(mk(0, 16'h0000, 32'hFFFC0020, '0, CTI_CLASSIC, BTE_LINEAR, 0, 8'h67, 0), f, n);
        chk("t6 read after reset", f.dat, 128'h12);
        txn(mk(0, 16'h0000, 32'h00001000, '0, CTI_CLASSIC, BTE_LINEAR, 0, 8'h68, 0), f, n);
        chk("t6 miss no response", 128'(n), 128'(0));

        // Randomized traffic.
        for (int t = 0; t < 300; t++) begin
            line  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : $urandom_range(1016, 1023);
            adr   = BASE | 32'(line * 16) | 32'($urandom_range(0, 15));
            sel_r = $urandom_range(0, 99);
            if (sel_r < 5) adr = $urandom & 32'h7FFF_FFFF;
            we    = (sel_r < 45);
            if ($urandom_range(0, 9) < (we ? 1 : 5)) cti = CTI_INCR;
            else cti = ($urandom_range(0, 1) == 1) ? CTI_EOB : CTI_CLASSIC;
            r = mk(we, 16'($urandom), adr, {$urandom, $urandom, $urandom, $urandom}, cti,
                   ($urandom_range(0, 9) == 0) ? 2'b01 : BTE_LINEAR,
                   (cti == CTI_INCR) ? 6'($urandom_range(0, 16)) : 6'd0,
                   8'($urandom), ($urandom_range(0, 4) == 0));
            txn(r, f, n);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
